alu_entry_ctrl: RTL and testbench
=================================

// Module: alu_entry_ctrl
// PURPOSE
//  Operator-entry front end for the board-level ALU demo; sits directly upstream of alu.
//  Debounces two push-buttons, sequences entry of operand A, operand B and opcode from the
//    switches, then presents them to the ALU.
//  Captures the ALU result and flags on the cycle after presentation, and exposes state for
//    the LED/7-seg display logic.
// PARAMETERS
//  DB_CNT   50000  consecutive stable cycles before a button level is accepted (1 ms @ 50 MHz)
//  DB_W     16     width of debounce counter; must hold DB_CNT-1
// PORTS
//  CLK         in   1   system clock, all state on rising edge
//  nRST        in   1   asynchronous, active-low reset
//  btn_n       in   2   raw active-low buttons, async; [0]=ENTER, [1]=CANCEL
//  sw          in   17  switch data; operands and opcode source
//  result_i    in   32  ALU result (combinational from portA/portB/aluop)
//  flags_i     in   3   ALU {negative, overflow, zero}
//  portA       out  32  operand 1 to ALU
//  portB       out  32  operand 2 to ALU
//  aluop       out  4   opcode to ALU (aluop_t encoding)
//  exec        out  1   1-cycle strobe, high in EXEC state
//  result_q    out  32  result captured at end of EXEC
//  flags_q     out  3   flags captured with result_q
//  state_o     out  3   one-hot-free encoding of FSM state for LEDs (values below)
// BEHAVIOUR
//  Reset: all outputs 0; state_o=ENTER_A; debounced levels=released (1), counters 0.
//  Button path, per button: 2-FF synchroniser -> debounce counter -> edge detector.
//    Counter clears whenever synced level == debounced level; otherwise increments.
//    When it reaches DB_CNT-1 while still differing, debounced level flips next edge and the
//      counter clears.
//    Press pulse = debounced 1->0 transition, exactly 1 cycle.
//    A raw fall held low yields the pulse DB_CNT+2 cycles after the first sampling edge.
//    Glitches shorter than DB_CNT synced cycles produce no pulse.
//    Release produces no event.
//  Sign extension: operand value = {{15{sw[16]}}, sw[16:0]}; opcode = sw[3:0].
//  FSM (state_o): ENTER_A=0, ENTER_B=1, ENTER_OP=2, EXEC=3, SHOW=4.
//    ENTER_A  --ENTER--> ENTER_B   portA <= ext(sw)
//    ENTER_B  --ENTER--> ENTER_OP  portB <= ext(sw)
//    ENTER_OP --ENTER--> EXEC      aluop <= sw[3:0]
//    EXEC     --always-> SHOW      exec=1; result_q<=result_i, flags_q<=flags_i at end of cycle
//    SHOW     --ENTER--> ENTER_A   portA, portB, aluop cleared to 0
//  CANCEL from any state -> ENTER_A next cycle.
//    Clears portA, portB, aluop; result_q and flags_q retained.
//  ENTER and CANCEL pulses in the same cycle: CANCEL wins, ENTER discarded.
//  In EXEC, a coincident ENTER is ignored and CANCEL is honoured.
//    CANCEL in EXEC still captures result_q that cycle.
//  Pulses are single-cycle; holding a button never advances more than one state.
//  portA/portB/aluop are registered and stable from load until the next load or clear.
//    ALU inputs are therefore glitch-free during EXEC.
//  nRST mid-entry or mid-debounce: immediate return to reset values; no pulse emitted after
//    release of reset unless the button is re-pressed.
// CONFIGURATION
//  ALU_ENTRY_CHAIN_EN defined:
//    SHOW --ENTER--> ENTER_B instead of ENTER_A.
//    portA <= result_q (accumulator chaining); portB and aluop cleared.
//    CANCEL behaviour unchanged.
//  Not defined: SHOW --ENTER--> ENTER_A as above; no feedback path from result_q to portA.
// TESTING  (DB_CNT=4 in simulation)
//  1. Reset: nRST low 3 cycles -> all outputs 0, state_o=0; no exec during or after.
//  2. Full sequence:
//     - sw=0x00005 ENTER, sw=0x00003 ENTER, sw=ADD ENTER.
//     - Expect exec high exactly 1 cycle.
//     - result_q=0x00000008 and flags_q=3'b000 in SHOW (state_o=4).
//  3. Debounce:
//     - btn_n[0] low 3 cycles then high -> no state change.
//     - Held low 20 cycles -> exactly one advance, pulse at cycle DB_CNT+2=6.
//  4. Sign extension: sw=17'h10000 loaded as A -> portA=0xFFFF0000.
//  5. Cancel: reach ENTER_OP with A=5, B=3, then press ENTER and CANCEL together.
//     Expect state_o=0, portA=portB=aluop=0, previous result_q unchanged.
//  6. Chaining, built with and without ALU_ENTRY_CHAIN_EN: after test 2, press ENTER in SHOW.
//     - With: state_o=1, portA=0x00000008.
//     - Without: state_o=0, portA=0.

Source files
------------

// File: rtl/alu_entry_ctrl.sv
// Operator-entry front end for the ALU demo: debounces ENTER/CANCEL and sequences A, B, opcode.
// Optional accumulator chaining (SHOW -> ENTER_B with portA <= result_q) under ALU_ENTRY_CHAIN_EN.
module alu_entry_ctrl #(
    parameter int unsigned DB_CNT = 50000,
    parameter int unsigned DB_W   = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  btn_n,
    input  logic [16:0] sw,
    input  logic [31:0] result_i,
    input  logic [2:0]  flags_i,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluop,
    output logic        exec,
    output logic [31:0] result_q,
    output logic [2:0]  flags_q,
    output logic [2:0]  state_o
);

    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CNT - 1);

    typedef enum logic [2:0] {
        StEnterA  = 3'd0,
        StEnterB  = 3'd1,
        StEnterOp = 3'd2,
        StExec    = 3'd3,
        StShow    = 3'd4
    } state_e;

    logic [1:0]      sync1_q, sync2_q, db_q, db_prev_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [1:0]      press;
    logic            enter_p, cancel_p;

    state_e      state_q, state_d;
    logic [31:0] porta_q, porta_d, portb_q, portb_d, res_q, res_d;
    logic [3:0]  op_q, op_d;
    logic [2:0]  flg_q, flg_d;
    logic [31:0] sw_ext;

    // Button path: 2-FF sync, then the debounced level only follows after DB_CNT stable samples.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DbLast) begin
                    cnt_q[i] <= '0;
                    db_q[i]  <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press = debounced 1->0; release is not an event.
    assign press    = db_prev_q & ~db_q;
    assign cancel_p = press[1];
    assign enter_p  = press[0] & ~press[1];
    assign sw_ext   = {{15{sw[16]}}, sw};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StEnterA;
            porta_q <= '0;
            portb_q <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            porta_q <= porta_d;
            portb_q <= portb_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        porta_d = porta_q;
        portb_d = portb_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;

        // Capture happens in EXEC even when CANCEL arrives in the same cycle.
        if (state_q == StExec) begin
            res_d = result_i;
            flg_d = flags_i;
        end

        if (cancel_p) begin
            state_d = StEnterA;
            porta_d = '0;
            portb_d = '0;
            op_d    = '0;
        end else begin
            unique case (state_q)
                StEnterA: begin
                    if (enter_p) begin
                        porta_d = sw_ext;
                        state_d = StEnterB;
                    end
                end
                StEnterB: begin
                    if (enter_p) begin
                        portb_d = sw_ext;
                        state_d = StEnterOp;
                    end
                end
                StEnterOp: begin
                    if (enter_p) begin
                        op_d    = sw[3:0];
                        state_d = StExec;
                    end
                end
                StExec: begin
                    state_d = StShow;
                end
                StShow: begin
                    if (enter_p) begin
                        portb_d = '0;
                        op_d    = '0;
`ifdef ALU_ENTRY_CHAIN_EN
                        porta_d = res_q;
                        state_d = StEnterB;
`else
                        porta_d = '0;
                        state_d = StEnterA;
`endif
                    end
                end
                default: begin
                    state_d = StEnterA;
                    porta_d = '0;
                    portb_d = '0;
                    op_d    = '0;
                end
            endcase
        end
    end

    assign portA    = porta_q;
    assign portB    = portb_q;
    assign aluop    = op_q;
    assign exec     = (state_q == StExec);
    assign result_q = res_q;
    assign flags_q  = flg_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Self-checking bench for alu_entry_ctrl with DB_CNT=4 and a small stand-in ALU.
module tb_alu_entry_ctrl;

    localparam int unsigned DB_CNT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  btn_n;
    logic [16:0] sw;
    logic [31:0] result_i;
    logic [2:0]  flags_i;
    logic [31:0] portA, portB, result_q;
    logic [3:0]  aluop;
    logic        exec;
    logic [2:0]  flags_q, state_o;

    alu_entry_ctrl #(.DB_CNT(DB_CNT), .DB_W(16)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .btn_n   (btn_n),
        .sw      (sw),
        .result_i(result_i),
        .flags_i (flags_i),
        .portA   (portA),
        .portB   (portB),
        .aluop   (aluop),
        .exec    (exec),
        .result_q(result_q),
        .flags_q (flags_q),
        .state_o (state_o)
    );

    always #5 CLK = ~CLK;

    // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR; flags {neg, ovf, zero}.
    logic ovf;
    always_comb begin
        result_i = '0;
        ovf      = 1'b0;
        case (aluop)
            4'd0: begin
                result_i = portA + portB;
                ovf = (portA[31] == portB[31]) && (result_i[31] != portA[31]);
            end
            4'd1: begin
                result_i = portA - portB;
                ovf = (portA[31] != portB[31]) && (result_i[31] != portA[31]);
            end
            4'd2: result_i = portA & portB;
            4'd3: result_i = portA | portB;
            default: result_i = '0;
        endcase
        flags_i = {result_i[31], ovf, (result_i == 32'd0)};
    end

    typedef struct {
        logic [16:0] a;
        logic [16:0] b;
        logic [3:0]  op;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
    } sb_t;

    vec_t vecs [5];
    sb_t  sb_q [$];

    int   n_checks    = 0;
    int   n_fail      = 0;
    int   exec_cycles = 0;
    int   n_pushed    = 0;
    logic exec_d1     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: one cycle after exec, the captured result must match the queued expectation.
    always @(negedge CLK) begin
        sb_t e;
        if (exec_d1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_exec: got exec with empty queue expected none");
            end else begin
                e = sb_q.pop_front();
                check("sb_result_q", result_q, e.res);
                check("sb_flags_q", {29'd0, flags_q}, {29'd0, e.flags});
                check("sb_state_show", {29'd0, state_o}, 32'd4);
            end
        end
        if (exec) exec_cycles <= exec_cycles + 1;
        exec_d1 <= exec;
    end

    task automatic press(input logic [1:0] mask);
        btn_n = ~mask;
        repeat (8) @(negedge CLK);
        btn_n = 2'b11;
        repeat (8) @(negedge CLK);
    endtask

    initial begin
        vecs[0] = '{a: 17'h00005, b: 17'h00003, op: 4'd0, exp_a: 32'h00000005,
                    exp_b: 32'h00000003, exp_res: 32'h00000008, exp_flags: 3'b000};
        vecs[1] = '{a: 17'h10000, b: 17'h00001, op: 4'd0, exp_a: 32'hFFFF0000,
                    exp_b: 32'h00000001, exp_res: 32'hFFFF0001, exp_flags: 3'b100};
        vecs[2] = '{a: 17'h00003, b: 17'h00003, op: 4'd1, exp_a: 32'h00000003,
                    exp_b: 32'h00000003, exp_res: 32'h00000000, exp_flags: 3'b001};
        vecs[3] = '{a: 17'h1FFFF, b: 17'h00002, op: 4'd2, exp_a: 32'hFFFFFFFF,
                    exp_b: 32'h00000002, exp_res: 32'h00000002, exp_flags: 3'b000};
        vecs[4] = '{a: 17'h00F0F, b: 17'h000F0, op: 4'd3, exp_a: 32'h00000F0F,
                    exp_b: 32'h000000F0, exp_res: 32'h00000FFF, exp_flags: 3'b000};

        nRST  = 1'b0;
        btn_n = 2'b11;
        sw    = '0;
        repeat (3) @(negedge CLK);
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_portA", portA, 32'd0);
        check("rst_portB", portB, 32'd0);
        check("rst_aluop", {28'd0, aluop}, 32'd0);
        check("rst_exec", {31'd0, exec}, 32'd0);
        check("rst_result_q", result_q, 32'd0);
        check("rst_flags_q", {29'd0, flags_q}, 32'd0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_state", {29'd0, state_o}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            sw = vecs[i].a;
            press(2'b01);
            check("vec_state_b", {29'd0, state_o}, 32'd1);
            check("vec_portA", portA, vecs[i].exp_a);
            sw = vecs[i].b;
            press(2'b01);
            check("vec_state_op", {29'd0, state_o}, 32'd2);
            check("vec_portB", portB, vecs[i].exp_b);
            sw = {13'd0, vecs[i].op};
            sb_q.push_back('{res: vecs[i].exp_res, flags: vecs[i].exp_flags});
            n_pushed++;
            press(2'b01);
            check("vec_state_show", {29'd0, state_o}, 32'd4);
            check("vec_aluop", {28'd0, aluop}, {28'd0, vecs[i].op});
            press(2'b01);
`ifdef ALU_ENTRY_CHAIN_EN
            check("chain_state", {29'd0, state_o}, 32'd1);
            check("chain_portA", portA, vecs[i].exp_res);
`else
            check("chain_state", {29'd0, state_o}, 32'd0);
            check("chain_portA", portA, 32'd0);
`endif
            check("chain_portB", portB, 32'd0);
            press(2'b10);
            check("cancel_state", {29'd0, state_o}, 32'd0);
            check("cancel_result_kept", result_q, vecs[i].exp_res);
        end

        // ENTER and CANCEL together in ENTER_OP: cancel wins, result retained.
        sw = 17'h00005;
        press(2'b01);
        sw = 17'h00003;
        press(2'b01);
        check("both_pre_state", {29'd0, state_o}, 32'd2);
        sw = 17'h00000;
        press(2'b11);
        check("both_state", {29'd0, state_o}, 32'd0);
        check("both_portA", portA, 32'd0);
        check("both_portB", portB, 32'd0);
        check("both_aluop", {28'd0, aluop}, 32'd0);
        check("both_result_q", result_q, 32'h00000FFF);

        // Glitch of 3 cycles must not advance.
        sw    = 17'h00007;
        btn_n = 2'b10;
        repeat (3) @(negedge CLK);
        btn_n = 2'b11;
        repeat (10) @(negedge CLK);
        check("glitch_state", {29'd0, state_o}, 32'd0);

        // Held press: pulse after DB_CNT+2 edges, FSM moves on the following edge, once only.
        btn_n = 2'b10;
        repeat (DB_CNT + 2) @(negedge CLK);
        check("hold_before_adv", {29'd0, state_o}, 32'd0);
        @(negedge CLK);
        check("hold_adv", {29'd0, state_o}, 32'd1);
        check("hold_portA", portA, 32'h00000007);
        repeat (13) @(negedge CLK);
        btn_n = 2'b11;
        repeat (8) @(negedge CLK);
        check("hold_once", {29'd0, state_o}, 32'd1);
        press(2'b10);
        check("final_cancel", {29'd0, state_o}, 32'd0);

        check("exec_cycles", exec_cycles, n_pushed);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
